// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: selects the WB value,
// commits it, serves two bypassed ID read ports, and keeps a WB forwarding record.

module wb_regfile_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] rd_data
);
  // Hardwired zero wins over the bypass; the bypass wins over stale storage.
  always_comb begin
    rd_data = store_data;
    if (rd_idx == '0)
      rd_data = '0;
    else if (wr_en && (rd_idx == wr_idx))
      rd_data = wr_data;
  end
endmodule

module wb_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               regWrite,
  input  logic               memReg,
  input  logic [DATA_W-1:0]  readData,
  input  logic [DATA_W-1:0]  address_out,
  input  logic [ADDR_W-1:0]  ex_mux_out,
  input  logic [ADDR_W-1:0]  readReg1,
  input  logic [ADDR_W-1:0]  readReg2,
  output logic [DATA_W-1:0]  readData1,
  output logic [DATA_W-1:0]  readData2,
  output logic [DATA_W-1:0]  wbData,
  output logic               fwdValid,
  output logic [ADDR_W-1:0]  fwdReg,
  output logic [DATA_W-1:0]  fwdData,
  output logic [COUNT_W-1:0] wbCount
);
  localparam int NUM_REGS  = 1 << ADDR_W;
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wb_rec_t;

  logic [NUM_REGS-1:0][DATA_W-1:0]   regs;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]  rd_idx;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  store_data;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  rd_data;
  logic                              commit;
  logic                              fwd_vld;
  wb_rec_t                           fwd_rec;
  logic [COUNT_W-1:0]                cnt;

  assign wbData = memReg ? readData : address_out;
  assign commit = regWrite && (ex_mux_out != '0);

  assign rd_idx    = {readReg2, readReg1};
  assign readData1 = rd_data[0];
  assign readData2 = rd_data[1];

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_rd
      assign store_data[p] = regs[rd_idx[p]];
      wb_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_rdport (
        .rd_idx     (rd_idx[p]),
        .wr_en      (commit),
        .wr_idx     (ex_mux_out),
        .wr_data    (wbData),
        .store_data (store_data[p]),
        .rd_data    (rd_data[p])
      );
    end
  endgenerate

  // Entry 0 is never written (commit excludes it), so it stays at its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs    <= '0;
      fwd_vld <= 1'b0;
      fwd_rec <= '0;
      cnt     <= '0;
    end else begin
      fwd_vld <= commit;
      if (commit) begin
        regs[ex_mux_out] <= wbData;
        fwd_rec          <= '{idx: ex_mux_out, data: wbData};
        cnt              <= cnt + COUNT_W'(1);
      end
    end
  end

  assign fwdValid = fwd_vld;
  assign fwdReg   = fwd_rec.idx;
  assign fwdData  = fwd_rec.data;
  assign wbCount  = cnt;
endmodule
